mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the core's single shared data/instruction RAM port. Accepts fetch requests from the IFU and load/store requests from the LSU over valid/ready handshakes, grants one at a time, drives the RAM write/address/format lines for a fixed access latency, and returns read data (or a write acknowledge) to the winner. Sits between IFU/LSU and the byte-addressed RAM.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- MEM_LAT, 1, RAM access cycles (≥1); read data sampled in last busy cycle
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_WIDTH  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, ifu_rdata valid
- ifu_rdata  out  DATA_WIDTH  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_we  in  1  1 = store, 0 = load
- lsu_format  in  2  00 byte, 01 half, 10/11 word
- lsu_addr  in  ADDR_WIDTH  load/store address
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_resp_valid  out  1  one-cycle pulse; load data valid or store done
- lsu_rdata  out  DATA_WIDTH  load data (0 for stores)
- mem_en  out  1  write strobe qualifier; mem_we = lsu_we & mem_en
- mem_we  out  1  RAM write enable
- mem_format  out  2  RAM access format
- mem_addr  out  ADDR_WIDTH  RAM address (write and read)
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM combinational read data

## Operation
- FSM: IDLE, BUSY, RESP. Reset → IDLE.
- Accept window: state IDLE or RESP. Ready asserted combinationally only to the arbitration winner among valid requesters; the other sees ready=0. Transfer = valid & ready.
- On transfer: latch owner, we, format, addr, wdata; IFU requests latch we=0, format=2'b10. Load counter with MEM_LAT-1; go BUSY.
- BUSY: mem_addr/format/wdata driven from latched regs; mem_en=1 and mem_we=latched we only in first BUSY cycle (exactly one write per store). Counter decrements; when 0, capture mem_rdata into owner's rdata reg, go RESP.
- RESP: owner's resp_valid=1 for this single cycle; new request may be accepted same cycle (→BUSY) else → IDLE. No response backpressure.
- Requesters hold valid and payload stable until ready; arbiter never drops a valid request.
- Idle mem_* outputs: mem_en=0, mem_we=0, others hold last value.
- Counter width $clog2(MEM_LAT+1); no wrap.

## Timing
- Reset (async assert): state IDLE, all resp_valid/ready/mem_en/mem_we = 0, rdata regs = 0, mem_addr/wdata/format = 0, last-grant = IFU. In-flight transaction aborted, no response, no write issued after reset assertion.
- Latency: request accepted cycle T → mem_en in T+1 → resp_valid in T+MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+1 cycles (accept overlaps RESP).
- Simultaneous valid: resolved per Configuration; loser waits, served next window.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on conflict, winner is requester not granted last (last-grant reg updated each transfer; reset value IFU, so LSU wins first conflict). Single requester always wins.
- Undefined: fixed priority, LSU always wins conflicts; IFU may starve under continuous LSU traffic (by design, LSU stalls pipeline).

## Test plan
- Reset mid-BUSY with LSU store to 0x80000010 → no mem_we after reset edge, no lsu_resp_valid, all outputs 0.
- IFU only, addr 0x80000000, RAM holds 0x00000413, MEM_LAT=1 → ready at T, mem_addr=0x80000000 at T+1, ifu_resp_valid & ifu_rdata=0x00000413 at T+2.
- LSU byte store 0xAB to 0x80000005 then word load 0x80000004 → single mem_we pulse format 00; load returns byte 1 = 0xAB, lsu_resp_valid each one cycle.
- Both valid continuously, macro undefined → LSU granted every window, ifu_req_ready stays 0.
- Both valid continuously, MEM_ARB_ROUND_ROBIN_EN defined → grants LSU, IFU, LSU, IFU; back-to-back accept in RESP, period MEM_LAT+1.
- MEM_LAT=3 → counter spans 3 BUSY cycles, mem_en only first, resp at T+4.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU request/response, LSU request/response and RAM port signals
// shared by mem_arbiter (slave) and the requester/RAM side (master).
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_addr;
    logic                  ifu_resp_valid;
    logic [DATA_WIDTH-1:0] ifu_rdata;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic                  lsu_we;
    logic [1:0]            lsu_format;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic                  lsu_resp_valid;
    logic [DATA_WIDTH-1:0] lsu_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [1:0]            mem_format;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_we, lsu_format, lsu_addr, lsu_wdata,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_en, mem_we, mem_format, mem_addr, mem_wdata
    );

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_we, lsu_format, lsu_addr, lsu_wdata,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_en, mem_we, mem_format, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter and sequencer for the shared RAM port (IDLE/BUSY/RESP).
// MEM_ARB_ROUND_ROBIN_EN selects round-robin conflicts; default is fixed LSU priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  own_lsu;
    logic                  lat_we;
    logic [1:0]            lat_fmt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] ifu_rdata_q;
    logic [DATA_WIDTH-1:0] lsu_rdata_q;
    logic                  accept_win, lsu_wins, lsu_xfer, ifu_xfer, xfer, done;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  last_lsu;
`endif

    // Ready is gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        accept_win = rst_n && (state == IDLE || state == RESP);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        lsu_wins = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
`else
        lsu_wins = bus.lsu_req_valid;
`endif
        lsu_xfer = accept_win && lsu_wins;
        ifu_xfer = accept_win && bus.ifu_req_valid && !lsu_wins;
        xfer     = lsu_xfer || ifu_xfer;
        done     = (state == BUSY) && (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (xfer) state_nxt = BUSY;
            BUSY:    if (done) state_nxt = RESP;
            RESP:    state_nxt = xfer ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            own_lsu     <= 1'b0;
            lat_we      <= 1'b0;
            lat_fmt     <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_lsu    <= 1'b0;
`endif
        end else begin
            if (lsu_xfer) begin
                own_lsu   <= 1'b1;
                lat_we    <= bus.lsu_we;
                lat_fmt   <= bus.lsu_format;
                lat_addr  <= bus.lsu_addr;
                lat_wdata <= bus.lsu_wdata;
            end else if (ifu_xfer) begin
                own_lsu   <= 1'b0;
                lat_we    <= 1'b0;
                lat_fmt   <= 2'b10;
                lat_addr  <= bus.ifu_addr;
                lat_wdata <= '0;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (xfer) last_lsu <= lsu_xfer;
`endif
            if (xfer)
                cnt <= CNT_INIT;
            else if (state == BUSY && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (done) begin
                if (own_lsu) lsu_rdata_q <= lat_we ? '0 : bus.mem_rdata;
                else         ifu_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // The first BUSY cycle is the one where the counter still holds its load value.
    always_comb begin
        bus.ifu_req_ready  = ifu_xfer;
        bus.lsu_req_ready  = lsu_xfer;
        bus.mem_en         = (state == BUSY) && (cnt == CNT_INIT);
        bus.mem_we         = (state == BUSY) && (cnt == CNT_INIT) && lat_we;
        bus.mem_format     = lat_fmt;
        bus.mem_addr       = lat_addr;
        bus.mem_wdata      = lat_wdata;
        bus.ifu_resp_valid = (state == RESP) && !own_lsu;
        bus.lsu_resp_valid = (state == RESP) && own_lsu;
        bus.ifu_rdata      = ifu_rdata_q;
        bus.lsu_rdata      = lsu_rdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one DUT at MEM_LAT=1 with a byte RAM model,
// one at MEM_LAT=3 with a constant read bus.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;

    logic [7:0] ram [0:63];
    logic [5:0] wa;
    logic [3:0] ra;

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    always #5 clk = ~clk;

    assign wa = bus1.mem_addr[5:0];
    assign ra = bus1.mem_addr[5:2];
    assign bus1.mem_rdata = {ram[{ra, 2'b11}], ram[{ra, 2'b10}], ram[{ra, 2'b01}], ram[{ra, 2'b00}]};
    assign bus3.mem_rdata = 32'h5A5A_0413;

    // Little-endian byte RAM; also counts write strobes.
    always @(posedge clk) begin
        if (bus1.mem_we) begin
            we_cnt++;
            ram[wa] = bus1.mem_wdata[7:0];
            if (bus1.mem_format != 2'b00) ram[wa + 6'd1] = bus1.mem_wdata[15:8];
            if (bus1.mem_format[1]) begin
                ram[wa + 6'd2] = bus1.mem_wdata[23:16];
                ram[wa + 6'd3] = bus1.mem_wdata[31:24];
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        bus1.ifu_req_valid = 1'b1;
        bus1.ifu_addr = 32'h8000_0000;
        @(negedge clk);
        total++;
        if ({bus1.ifu_req_ready, bus1.lsu_req_ready, bus1.ifu_resp_valid, bus1.lsu_resp_valid,
             bus1.mem_en, bus1.mem_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000", {bus1.ifu_req_ready, bus1.lsu_req_ready,
                     bus1.ifu_resp_valid, bus1.lsu_resp_valid, bus1.mem_en, bus1.mem_we});
        end
        total++;
        if ({bus1.mem_addr, bus1.mem_wdata, bus1.mem_format, bus1.ifu_rdata, bus1.lsu_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%h wdata=%h fmt=%b ifu_rd=%h lsu_rd=%h exp all 0",
                     bus1.mem_addr, bus1.mem_wdata, bus1.mem_format, bus1.ifu_rdata, bus1.lsu_rdata);
        end
        bus1.ifu_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_ifu_fetch;
        @(posedge clk); #1;
        bus1.ifu_req_valid = 1'b1;
        bus1.ifu_addr = 32'h8000_0000;
        @(negedge clk);
        total++;
        if ({bus1.ifu_req_ready, bus1.lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL ifu_ready got=%b exp=10", {bus1.ifu_req_ready, bus1.lsu_req_ready});
        end
        @(posedge clk); #1;
        bus1.ifu_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.mem_format, bus1.mem_addr, bus1.ifu_resp_valid}
            !== {1'b1, 1'b0, 2'b10, 32'h8000_0000, 1'b0}) begin
            bad++;
            $display("FAIL ifu_busy got en=%b we=%b fmt=%b addr=%h resp=%b exp 1 0 10 80000000 0",
                     bus1.mem_en, bus1.mem_we, bus1.mem_format, bus1.mem_addr, bus1.ifu_resp_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus1.ifu_resp_valid, bus1.ifu_rdata} !== {1'b1, 32'h0000_0413}) begin
            bad++;
            $display("FAIL ifu_resp got valid=%b data=%h exp 1 00000413", bus1.ifu_resp_valid, bus1.ifu_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus1.ifu_resp_valid, bus1.mem_en, bus1.mem_addr} !== {1'b0, 1'b0, 32'h8000_0000}) begin
            bad++;
            $display("FAIL ifu_idle got resp=%b en=%b addr=%h exp 0 0 80000000",
                     bus1.ifu_resp_valid, bus1.mem_en, bus1.mem_addr);
        end
    endtask

    task automatic test_store_load;
        int w0;
        w0 = we_cnt;
        @(posedge clk); #1;
        bus1.lsu_req_valid = 1'b1;
        bus1.lsu_we = 1'b1;
        bus1.lsu_format = 2'b00;
        bus1.lsu_addr = 32'h8000_0005;
        bus1.lsu_wdata = 32'h0000_00AB;
        @(negedge clk);
        total++;
        if (bus1.lsu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL st_ready got=%b exp=1", bus1.lsu_req_ready);
        end
        @(posedge clk); #1;
        bus1.lsu_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.mem_format, bus1.mem_addr, bus1.mem_wdata}
            !== {1'b1, 1'b1, 2'b00, 32'h8000_0005, 32'h0000_00AB}) begin
            bad++;
            $display("FAIL st_busy got en=%b we=%b fmt=%b addr=%h wdata=%h exp 1 1 00 80000005 000000ab",
                     bus1.mem_en, bus1.mem_we, bus1.mem_format, bus1.mem_addr, bus1.mem_wdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus1.lsu_resp_valid, bus1.lsu_rdata, bus1.mem_we} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL st_resp got valid=%b data=%h we=%b exp 1 00000000 0",
                     bus1.lsu_resp_valid, bus1.lsu_rdata, bus1.mem_we);
        end
        @(posedge clk); #1;
        bus1.lsu_req_valid = 1'b1;
        bus1.lsu_we = 1'b0;
        bus1.lsu_format = 2'b10;
        bus1.lsu_addr = 32'h8000_0004;
        @(negedge clk);
        total++;
        if ({bus1.lsu_resp_valid, bus1.lsu_req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL ld_ready got resp=%b ready=%b exp 0 1", bus1.lsu_resp_valid, bus1.lsu_req_ready);
        end
        total++;
        if (we_cnt - w0 !== 1) begin
            bad++;
            $display("FAIL st_we_count got=%0d exp=1", we_cnt - w0);
        end
        @(posedge clk); #1;
        bus1.lsu_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.mem_addr} !== {1'b1, 1'b0, 32'h8000_0004}) begin
            bad++;
            $display("FAIL ld_busy got en=%b we=%b addr=%h exp 1 0 80000004",
                     bus1.mem_en, bus1.mem_we, bus1.mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus1.lsu_resp_valid, bus1.lsu_rdata} !== {1'b1, 32'h1122_AB44}) begin
            bad++;
            $display("FAIL ld_resp got valid=%b data=%h exp 1 1122ab44", bus1.lsu_resp_valid, bus1.lsu_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (bus1.lsu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ld_pulse got=%b exp=0", bus1.lsu_resp_valid);
        end
    endtask

    task automatic test_reset_mid_busy;
        int w0;
        w0 = we_cnt;
        @(posedge clk); #1;
        bus1.lsu_req_valid = 1'b1;
        bus1.lsu_we = 1'b1;
        bus1.lsu_format = 2'b10;
        bus1.lsu_addr = 32'h8000_0010;
        bus1.lsu_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus1.lsu_req_valid = 1'b0;
        #1;
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.lsu_resp_valid, bus1.lsu_req_ready, bus1.ifu_req_ready,
             bus1.mem_addr, bus1.mem_wdata, bus1.mem_format} !== '0) begin
            bad++;
            $display("FAIL rst_busy got en=%b we=%b resp=%b addr=%h wdata=%h fmt=%b exp all 0",
                     bus1.mem_en, bus1.mem_we, bus1.lsu_resp_valid, bus1.mem_addr, bus1.mem_wdata,
                     bus1.mem_format);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({bus1.lsu_resp_valid, bus1.mem_en} !== 2'b00) begin
                bad++;
                $display("FAIL rst_no_resp cyc=%0d got resp=%b en=%b exp 0 0", c, bus1.lsu_resp_valid, bus1.mem_en);
            end
            @(posedge clk); #1;
        end
        total++;
        if ({we_cnt - w0, ram[16], ram[17], ram[18], ram[19]} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL rst_no_write got writes=%0d ram=%h%h%h%h exp 0 00000000",
                     we_cnt - w0, ram[19], ram[18], ram[17], ram[16]);
        end
    endtask

    task automatic test_arbitration;
        logic exp_lsu;
        logic prev_lsu;
        prev_lsu = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus1.ifu_req_valid = 1'b1;
        bus1.ifu_addr = 32'h8000_0000;
        bus1.lsu_req_valid = 1'b1;
        bus1.lsu_we = 1'b0;
        bus1.lsu_format = 2'b10;
        bus1.lsu_addr = 32'h8000_0004;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_lsu = (k % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            @(negedge clk);
            total++;
            if ({bus1.lsu_req_ready, bus1.ifu_req_ready} !== {exp_lsu, ~exp_lsu}) begin
                bad++;
                $display("FAIL arb_grant win=%0d got lsu/ifu=%b exp=%b", k,
                         {bus1.lsu_req_ready, bus1.ifu_req_ready}, {exp_lsu, ~exp_lsu});
            end
            if (k > 0) begin
                total++;
                if ({bus1.lsu_resp_valid, bus1.ifu_resp_valid} !== {prev_lsu, ~prev_lsu}) begin
                    bad++;
                    $display("FAIL arb_resp win=%0d got lsu/ifu=%b exp=%b", k,
                             {bus1.lsu_resp_valid, bus1.ifu_resp_valid}, {prev_lsu, ~prev_lsu});
                end
            end
            prev_lsu = exp_lsu;
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({bus1.lsu_req_ready, bus1.ifu_req_ready, bus1.mem_en} !== 3'b001) begin
                bad++;
                $display("FAIL arb_busy win=%0d got rdy_l/rdy_i/en=%b exp=001", k,
                         {bus1.lsu_req_ready, bus1.ifu_req_ready, bus1.mem_en});
            end
            @(posedge clk);
        end
        #1;
        bus1.ifu_req_valid = 1'b0;
        bus1.lsu_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus1.lsu_resp_valid, bus1.ifu_resp_valid} !== {prev_lsu, ~prev_lsu}) begin
            bad++;
            $display("FAIL arb_last_resp got lsu/ifu=%b exp=%b",
                     {bus1.lsu_resp_valid, bus1.ifu_resp_valid}, {prev_lsu, ~prev_lsu});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency3;
        @(posedge clk); #1;
        bus3.ifu_req_valid = 1'b1;
        bus3.ifu_addr = 32'h8000_0040;
        @(negedge clk);
        total++;
        if (bus3.ifu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL lat3_ready got=%b exp=1", bus3.ifu_req_ready);
        end
        @(posedge clk); #1;
        bus3.ifu_req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if ({bus3.mem_en, bus3.mem_we, bus3.ifu_resp_valid} !== {c == 1, 1'b0, c == 4}) begin
                bad++;
                $display("FAIL lat3_seq T+%0d got en=%b we=%b resp=%b exp %b 0 %b", c,
                         bus3.mem_en, bus3.mem_we, bus3.ifu_resp_valid, c == 1, c == 4);
            end
            if (c <= 3) begin
                total++;
                if (bus3.mem_addr !== 32'h8000_0040) begin
                    bad++;
                    $display("FAIL lat3_addr T+%0d got=%h exp=80000040", c, bus3.mem_addr);
                end
            end
            if (c == 4) begin
                total++;
                if (bus3.ifu_rdata !== 32'h5A5A_0413) begin
                    bad++;
                    $display("FAIL lat3_data got=%h exp=5a5a0413", bus3.ifu_rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        {ram[3], ram[2], ram[1], ram[0]} = 32'h0000_0413;
        {ram[7], ram[6], ram[5], ram[4]} = 32'h1122_3344;
        bus1.ifu_req_valid = 1'b0; bus1.ifu_addr = '0;
        bus1.lsu_req_valid = 1'b0; bus1.lsu_we = 1'b0; bus1.lsu_format = '0;
        bus1.lsu_addr = '0; bus1.lsu_wdata = '0;
        bus3.ifu_req_valid = 1'b0; bus3.ifu_addr = '0;
        bus3.lsu_req_valid = 1'b0; bus3.lsu_we = 1'b0; bus3.lsu_format = '0;
        bus3.lsu_addr = '0; bus3.lsu_wdata = '0;

        test_reset();
        test_ifu_fetch();
        test_store_load();
        test_reset_mid_busy();
        test_arbitration();
        test_latency3();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
